mem_port_arbiter: RTL and testbench

Shares the core's single external memory port between instruction fetch (IF) and data access (load/store from the ME stage). One transaction is outstanding at a time. Data requests have fixed priority, and a starvation counter guarantees fetch progress. The block sits between the pipeline's fetch/memory stages and the memory model or bus, and supplies the stall source the pipeline uses while a request is pending.

---
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and data access.
// Optional watchdog abort enabled by defining MEM_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_valid,
  output logic              mem_rd_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state, state_n;
  logic [3:0]        starve_cnt, starve_n;
  logic              if_gnt_n, d_gnt_n, if_done_n, d_done_n;
  logic              mem_valid_n, mem_rd_wr_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n, if_rdata_n, d_rdata_n, rdata_v;
  logic              grant_if, grant_d, finish;

`ifdef MEM_TIMEOUT_EN
  localparam int             WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = (WD_W)'(TIMEOUT - 1);
  logic [WD_W-1:0] wd_cnt, wd_n;
  logic            err_n;
`endif

  // Fetch only beats a pending data request once it has been passed over STARVE_MAX times.
  assign grant_if = if_req && (!d_req || starve_cnt == STARVE_LIM);
  assign grant_d  = d_req && !grant_if;

  always_comb begin
    state_n     = state;
    starve_n    = starve_cnt;
    if_gnt_n    = 1'b0;
    d_gnt_n     = 1'b0;
    if_done_n   = 1'b0;
    d_done_n    = 1'b0;
    mem_valid_n = mem_valid;
    mem_rd_wr_n = mem_rd_wr;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    if_rdata_n  = if_rdata;
    d_rdata_n   = d_rdata;
    finish      = mem_ready;
    rdata_v     = mem_rdata;
`ifdef MEM_TIMEOUT_EN
    wd_n        = '0;
    err_n       = 1'b0;
    if (!mem_ready && wd_cnt == WD_LAST) begin
      finish  = 1'b1;
      rdata_v = DATA_W'(32'hDEADBEEF);
    end
`endif
    case (state)
      IDLE: begin
        if (grant_if) begin
          state_n     = BUSY_I;
          if_gnt_n    = 1'b1;
          mem_valid_n = 1'b1;
          mem_rd_wr_n = 1'b1;
          mem_addr_n  = if_addr;
          mem_wdata_n = '0;
          starve_n    = '0;
        end else if (grant_d) begin
          state_n     = BUSY_D;
          d_gnt_n     = 1'b1;
          mem_valid_n = 1'b1;
          mem_rd_wr_n = !d_we;
          mem_addr_n  = d_addr;
          mem_wdata_n = d_wdata;
          if (if_req && starve_cnt != STARVE_LIM) starve_n = starve_cnt + 4'd1;
        end
      end
      BUSY_I, BUSY_D: begin
`ifdef MEM_TIMEOUT_EN
        wd_n = wd_cnt + 1'b1;
`endif
        if (finish) begin
          state_n     = IDLE;
          mem_valid_n = 1'b0;
          if (state == BUSY_I) begin
            if_done_n  = 1'b1;
            if_rdata_n = rdata_v;
          end else begin
            d_done_n  = 1'b1;
            // A completed store returns zero; an aborted one still reports the poison word.
            d_rdata_n = (mem_rd_wr || !mem_ready) ? rdata_v : '0;
          end
`ifdef MEM_TIMEOUT_EN
          err_n = !mem_ready;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      if_gnt     <= 1'b0;
      d_gnt      <= 1'b0;
      if_done    <= 1'b0;
      d_done     <= 1'b0;
      mem_valid  <= 1'b0;
      mem_rd_wr  <= 1'b1;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
`ifdef MEM_TIMEOUT_EN
      wd_cnt     <= '0;
      err        <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      starve_cnt <= starve_n;
      if_gnt     <= if_gnt_n;
      d_gnt      <= d_gnt_n;
      if_done    <= if_done_n;
      d_done     <= d_done_n;
      mem_valid  <= mem_valid_n;
      mem_rd_wr  <= mem_rd_wr_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      if_rdata   <= if_rdata_n;
      d_rdata    <= d_rdata_n;
`ifdef MEM_TIMEOUT_EN
      wd_cnt     <= wd_n;
      err        <= err_n;
`endif
    end
  end

`ifndef MEM_TIMEOUT_EN
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a simple latency-controlled memory responder.
// Timeout scenario is built only when MEM_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_gnt, if_done;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              d_gnt, d_done;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_valid, mem_rd_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              err;

  typedef struct {
    logic        is_if;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mem_lat = 1;
  bit   mem_stall = 1'b0;
  int   wait_cnt = 0;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .mem_valid(mem_valid), .mem_rd_wr(mem_rd_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "[TB] hung");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8002_0000) return 32'h27BD_FFE8;
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // One clock: scoreboard any completion, then update the memory responder.
  task automatic step();
    exp_t        e;
    logic [31:0] got;
    @(negedge clk);
    checks++;
    if (if_gnt && d_gnt) begin
      errors++;
      $display("FAIL gnt_exclusive: if_gnt=%0b d_gnt=%0b, required at most one", if_gnt, d_gnt);
    end
    if (if_done || d_done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: if_done=%0b d_done=%0b, required none", if_done, d_done);
      end else begin
        e = exp_q.pop_front();
        if ({if_done, d_done} !== {e.is_if, !e.is_if}) begin
          errors++;
          $display("FAIL done_owner: if_done=%0b d_done=%0b, required if=%0b", if_done, d_done, e.is_if);
        end
        got = e.is_if ? if_rdata : d_rdata;
        checks++;
        if (got !== e.rdata) begin
          errors++;
          $display("FAIL done_rdata: got %h, required %h", got, e.rdata);
        end
        checks++;
        if (err !== e.err) begin
          errors++;
          $display("FAIL done_err: got %0b, required %0b", err, e.err);
        end
      end
    end else if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_stray: got %0b without done, required 0", err);
    end
    if (mem_valid && !mem_stall && !reset) begin
      if (wait_cnt + 1 >= mem_lat) begin
        mem_ready = 1'b1;
        mem_rdata = mem_word(mem_addr);
        wait_cnt  = 0;
      end else begin
        mem_ready = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ready = 1'b0;
      wait_cnt  = 0;
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    if_req    = 1'b0;
    d_req     = 1'b0;
    mem_stall = 1'b0;
    step();
    step();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_gnt(output bit got_if, output bit ok, output int n);
    ok = 1'b0; got_if = 1'b0; n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n++;
      if (if_gnt || d_gnt) begin
        got_if = if_gnt;
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || mem_valid) && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || mem_valid) begin
      errors++;
      $display("FAIL %s_drain: pending=%0d mem_valid=%0b, required 0 and 0", name, exp_q.size(), mem_valid);
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    do_reset();
    checks++;
    if ({if_gnt, d_gnt, if_done, d_done, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_pulses: got %b, required 00000", {if_gnt, d_gnt, if_done, d_done, err});
    end
    checks++;
    if ({mem_valid, mem_rd_wr} !== 2'b01) begin
      errors++;
      $display("FAIL reset_mem_ctrl: valid/rd_wr=%b, required 01", {mem_valid, mem_rd_wr});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_mem_bus: addr=%h wdata=%h, required 0", mem_addr, mem_wdata);
    end
    checks++;
    if (if_rdata !== '0 || d_rdata !== '0) begin
      errors++;
      $display("FAIL reset_rdata: if=%h d=%h, required 0", if_rdata, d_rdata);
    end
  endtask

  task automatic test_if_fetch();
    int n = 0;
    exp_t e;
    $display("[TB] test_if_fetch");
    mem_lat = 2;
    if_req  = 1'b1;
    if_addr = 32'h8002_0000;
    step();
    checks++;
    if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_valid !== 1'b1 || mem_rd_wr !== 1'b1 ||
        mem_addr !== 32'h8002_0000) begin
      errors++;
      $display("FAIL if_grant: gnt=%0b valid=%0b rd_wr=%0b addr=%h, required 1 1 1 80020000",
               if_gnt, mem_valid, mem_rd_wr, mem_addr);
    end
    e.is_if = 1'b1; e.rdata = 32'h27BD_FFE8; e.err = 1'b0;
    exp_q.push_back(e);
    if_req = 1'b0;
    while (!if_done && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (n != mem_lat) begin
      errors++;
      $display("FAIL if_latency: done %0d cycles after gnt, required %0d", n, mem_lat);
    end
    drain("if_fetch");
  endtask

  task automatic test_store();
    int n = 0;
    exp_t e;
    $display("[TB] test_store");
    mem_lat = 3;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h8011_FFF0;
    d_wdata = 32'h1234_5678;
    step();
    checks++;
    if (d_gnt !== 1'b1 || mem_rd_wr !== 1'b0 || mem_addr !== 32'h8011_FFF0 || mem_wdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL store_grant: gnt=%0b rd_wr=%0b addr=%h wdata=%h, required 1 0 8011fff0 12345678",
               d_gnt, mem_rd_wr, mem_addr, mem_wdata);
    end
    e.is_if = 1'b0; e.rdata = 32'h0; e.err = 1'b0;
    exp_q.push_back(e);
    d_req = 1'b0;
    d_we  = 1'b0;
    while (!d_done && n < 10) begin
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== 32'h8011_FFF0 || mem_wdata !== 32'h1234_5678) begin
        errors++;
        $display("FAIL store_stable: valid=%0b addr=%h wdata=%h, required 1 8011fff0 12345678",
                 mem_valid, mem_addr, mem_wdata);
      end
      step();
      n++;
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL store_latency: done %0d cycles after gnt, required 3", n);
    end
    drain("store");
  endtask

  task automatic test_load();
    bit got_if, ok;
    int n;
    exp_t e;
    $display("[TB] test_load");
    mem_lat = 1;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h1000_0040;
    wait_gnt(got_if, ok, n);
    checks++;
    if (!ok || got_if || n != 1 || mem_rd_wr !== 1'b1) begin
      errors++;
      $display("FAIL load_grant: ok=%0b if=%0b cycles=%0d rd_wr=%0b, required 1 0 1 1", ok, got_if, n, mem_rd_wr);
    end
    e.is_if = 1'b0; e.rdata = mem_word(32'h1000_0040); e.err = 1'b0;
    exp_q.push_back(e);
    d_req = 1'b0;
    step();
    checks++;
    if (d_done !== 1'b1) begin
      errors++;
      $display("FAIL load_min_latency: d_done=%0b two cycles after request, required 1", d_done);
    end
    drain("load");
  endtask

  task automatic test_contention();
    bit got_if, ok, exp_if;
    int n, sm;
    exp_t e;
    $display("[TB] test_contention");
    do_reset();
    mem_lat = 1;
    if_req  = 1'b1;
    if_addr = 32'h0040_0100;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h1000_0200;
    sm = 0;
    for (int k = 0; k < 15; k++) begin
      wait_gnt(got_if, ok, n);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL contention_gnt_timeout: grant %0d missing, required a grant", k);
        break;
      end
      exp_if = (sm == STARVE_MAX);
      checks++;
      if (got_if !== exp_if) begin
        errors++;
        $display("FAIL contention_order: grant %0d if=%0b, required if=%0b", k, got_if, exp_if);
      end
      if (k > 0) begin
        checks++;
        if (n != 2) begin
          errors++;
          $display("FAIL back_to_back: grant %0d gap %0d cycles, required 2", k, n);
        end
      end
      if (exp_if) sm = 0;
      else if (sm < STARVE_MAX) sm++;
      e.is_if = got_if;
      e.rdata = got_if ? mem_word(32'h0040_0100) : mem_word(32'h1000_0200);
      e.err   = 1'b0;
      exp_q.push_back(e);
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    drain("contention");
  endtask

  task automatic test_reset_mid();
    bit got_if, ok;
    int n;
    exp_t e;
    $display("[TB] test_reset_mid");
    mem_stall = 1'b1;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h1000_0300;
    wait_gnt(got_if, ok, n);
    checks++;
    if (!ok || got_if) begin
      errors++;
      $display("FAIL rst_mid_grant: ok=%0b if=%0b, required 1 0", ok, got_if);
    end
    d_req = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset     = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    checks++;
    if (mem_valid !== 1'b0 || d_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_state: valid=%0b d_done=%0b, required 0 0", mem_valid, d_done);
    end
    step();
    checks++;
    if (mem_valid !== 1'b0 || d_done !== 1'b0 || if_gnt !== 1'b0 || d_gnt !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_late_ready: valid=%0b d_done=%0b gnt=%0b%0b, required all 0",
               mem_valid, d_done, if_gnt, d_gnt);
    end
    mem_stall = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h0040_0200;
    wait_gnt(got_if, ok, n);
    checks++;
    if (!ok || !got_if || n != 1) begin
      errors++;
      $display("FAIL rst_mid_fresh_if: ok=%0b if=%0b cycles=%0d, required 1 1 1", ok, got_if, n);
    end
    e.is_if = 1'b1; e.rdata = mem_word(32'h0040_0200); e.err = 1'b0;
    exp_q.push_back(e);
    if_req = 1'b0;
    drain("reset_mid");
  endtask

`ifndef MEM_TIMEOUT_EN
  task automatic test_stall();
    bit got_if, ok;
    int n;
    logic [31:0] a;
    exp_t e;
    $display("[TB] test_stall");
    mem_stall = 1'b1;
    mem_lat = 1;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h1000_0400;
    wait_gnt(got_if, ok, n);
    checks++;
    if (!ok || got_if) begin
      errors++;
      $display("FAIL stall_grant: ok=%0b if=%0b, required 1 0", ok, got_if);
    end
    e.is_if = 1'b0; e.rdata = mem_word(32'h1000_0400); e.err = 1'b0;
    exp_q.push_back(e);
    d_req   = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h0040_0300;
    a = mem_addr;
    for (int i = 0; i < 100; i++) begin
      step();
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== a || if_gnt !== 1'b0 || d_done !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d valid=%0b addr=%h if_gnt=%0b d_done=%0b, required 1 %h 0 0",
                 i, mem_valid, mem_addr, if_gnt, d_done, a);
      end
    end
    mem_stall = 1'b0;
    wait_gnt(got_if, ok, n);
    checks++;
    if (!ok || !got_if || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_release: ok=%0b if=%0b pending=%0d, required 1 1 0", ok, got_if, exp_q.size());
    end
    e.is_if = 1'b1; e.rdata = mem_word(32'h0040_0300); e.err = 1'b0;
    exp_q.push_back(e);
    if_req = 1'b0;
    drain("stall");
  endtask
`else
  task automatic test_timeout();
    bit got_if, ok;
    int n;
    exp_t e;
    $display("[TB] test_timeout");
    mem_stall = 1'b1;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h1000_0500;
    wait_gnt(got_if, ok, n);
    checks++;
    if (!ok || got_if) begin
      errors++;
      $display("FAIL timeout_grant: ok=%0b if=%0b, required 1 0", ok, got_if);
    end
    e.is_if = 1'b0; e.rdata = 32'hDEAD_BEEF; e.err = 1'b1;
    exp_q.push_back(e);
    d_req   = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h0040_0400;
    n = 0;
    while (!d_done && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n != TIMEOUT) begin
      errors++;
      $display("FAIL timeout_cycles: done %0d cycles after gnt, required %0d", n, TIMEOUT);
    end
    step();
    checks++;
    if (if_gnt !== 1'b1 || mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL timeout_next_if: if_gnt=%0b valid=%0b, required 1 1", if_gnt, mem_valid);
    end
    e.is_if = 1'b1; e.rdata = mem_word(32'h0040_0400); e.err = 1'b0;
    exp_q.push_back(e);
    if_req    = 1'b0;
    mem_stall = 1'b0;
    drain("timeout");
  endtask
`endif

  initial begin
    test_reset();
    test_if_fetch();
    test_store();
    test_load();
    test_contention();
    test_reset_mid();
`ifndef MEM_TIMEOUT_EN
    test_stall();
`else
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
